output_layer_accumulator: RTL
=============================

OUTPUT_LAYER_ACCUMULATOR -- requirements
Module: output_layer_accumulator

Interface
REQ-001: Parameter IMG_SIZE, default 256, is the number of input beats per image, with a minimum of 2.
REQ-002: Parameter CLASSES, default 10, is the number of output class scores.
REQ-003: Parameter SHIFT, default 7, is the arithmetic right-shift applied to each accumulator before clamping.
REQ-004: One clock; reset is asynchronous and active-high.
REQ-005: clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006: rst, input, 1 bit: asynchronous, active-high reset.
REQ-007: in_valid, input, 1 bit: in_pixel and in_weights carry a valid beat.
REQ-008: in_ready, output, 1 bit: the block accepts a beat this cycle.
REQ-009: in_pixel, input, 8 bits: unsigned activation.
REQ-010: in_weights, input, CLASSES x 8 bits: signed two's-complement weight per class for this beat.
REQ-011: out_valid, output, 1 bit: result holds a complete image score vector.
REQ-012: out_ready, input, 1 bit: the consumer takes result this cycle.
REQ-013: result, output, CLASSES x 8 bits: unsigned clamped score per class, formatted for the argmax prediction stage.

Function
REQ-014: The block has two states: ACCUM and DONE.
REQ-015: A beat is accepted when in_valid and in_ready are both 1; in_ready = (state == ACCUM).
REQ-016: On an accepted beat, each acc[i] (24-bit signed) becomes acc[i] + in_pixel * in_weights[i], with the pixel zero-extended and the weight sign-extended, and beat_cnt increments by 1.
REQ-017: beat_cnt width is $clog2(IMG_SIZE), and it counts 0 to IMG_SIZE-1.
REQ-018: On the accepted beat with beat_cnt == IMG_SIZE-1, the block registers result[i] = clamp(((acc[i] + product_i) >>> SHIFT), 0, 255), including that final product; beat_cnt returns to 0 and the state goes to DONE.
REQ-019: Clamping: a shifted value below 0 gives 0, a value above 255 gives 255, and any other value gives its low 8 bits.
REQ-020: out_valid = (state == DONE), so out_valid asserts exactly one cycle after the last beat is accepted.
REQ-021: In DONE, result and out_valid are held stable until out_ready is 1, regardless of in_valid.
REQ-022: In DONE with out_ready == 1, all acc are cleared to 0, the state goes to ACCUM, and in_ready is 1 on the next cycle.
REQ-023: No beats are accepted in DONE, and a beat presented then is neither consumed nor counted.
REQ-024: The accumulators shall not overflow for IMG_SIZE <= 256, since |255 * 128 * 256| < 2^23; larger IMG_SIZE is unsupported.
REQ-025: in_valid deasserted mid-image pauses accumulation with no loss of state and no change to beat_cnt.

Reset
REQ-026: Asserting rst, asynchronously and at any time (including mid-image or in DONE), forces state = ACCUM, beat_cnt = 0, all acc = 0, result = all zeros, and out_valid = 0.
REQ-027: During reset in_ready = 0, and in_ready becomes 1 in the first cycle after rst deasserts.
REQ-028: A partial image interrupted by reset is discarded; the next image starts from beat 0.

Verification
REQ-029: Ones test: 256 beats with pixel=1, weights class0=1 and all others=0 -> result[0]=2 (256>>>7), all other classes 0, and out_valid high one cycle after beat 256.
REQ-030: Saturation test: 256 beats with pixel=255 and class3 weight=127 -> acc=8,290,560, result[3]=255; with class5 weight=-128 -> result[5]=0.
REQ-031: Backpressure test: hold out_ready=0 for 5 cycles after out_valid -> result stable, in_ready=0, and beats presented are ignored; out_ready=1 -> out_valid drops next cycle, in_ready=1, and the next image accumulates from zero.
REQ-032: Gapped input test: in_valid toggling 1/0 across 256 beats -> result identical to the gap-free run and latency measured from the last accepted beat unchanged.
REQ-033: Mid-image reset test: rst pulse after 100 beats, then 256 beats of pixel=1 with class1 weight=2 -> result[1]=4 only (512>>>7), with no contribution from the first 100 beats.
REQ-034: Back-to-back test: out_ready tied to 1 with two consecutive images -> one DONE cycle between images, with the second result independent of the first.

Source files
------------

// File: rtl/output_layer_accumulator_if.sv
// Stream interface for the output-layer accumulator: pixel/weight beats in,
// clamped per-class score vector out, each with a valid/ready handshake.
interface output_layer_accumulator_if #(
   parameter int CLASSES = 10
);
   logic                     in_valid;
   logic                     in_ready;
   logic [7:0]               in_pixel;
   logic [CLASSES-1:0][7:0]  in_weights;
   logic                     out_valid;
   logic                     out_ready;
   logic [CLASSES-1:0][7:0]  result;

   modport master (
      output in_valid, in_pixel, in_weights, out_ready,
      input  in_ready, out_valid, result
   );

   modport slave (
      input  in_valid, in_pixel, in_weights, out_ready,
      output in_ready, out_valid, result
   );
endinterface

// File: rtl/output_layer_accumulator.sv
// Per-class MAC over IMG_SIZE beats, then shift/clamp into an 8-bit score
// vector that is held until the argmax stage takes it.
module output_layer_accumulator #(
   parameter int IMG_SIZE = 256,
   parameter int CLASSES  = 10,
   parameter int SHIFT    = 7
) (
   input  logic                        clk,
   input  logic                        rst,
   output_layer_accumulator_if.slave   bus
);
   localparam int CNT_W = $clog2(IMG_SIZE);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(IMG_SIZE - 1);

   typedef enum logic {ACCUM, DONE} state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
   logic             accept, last_beat, release_out;

   // in_ready is gated by rst so it stays low while reset is held.
   assign bus.in_ready  = (state_q == ACCUM) & ~rst;
   assign bus.out_valid = (state_q == DONE);
   assign accept        = bus.in_valid & bus.in_ready;
   assign last_beat     = (beat_cnt_q == LAST_CNT);
   assign release_out   = (state_q == DONE) & bus.out_ready;

   always_comb begin
      state_d    = state_q;
      beat_cnt_d = beat_cnt_q;
      unique case (state_q)
         ACCUM: begin
            if (accept) begin
               if (last_beat) begin
                  beat_cnt_d = '0;
                  state_d    = DONE;
               end else begin
                  beat_cnt_d = beat_cnt_q + 1'b1;
               end
            end
         end
         DONE: begin
            if (bus.out_ready) state_d = ACCUM;
         end
         default: state_d = ACCUM;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ACCUM;
         beat_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         beat_cnt_q <= beat_cnt_d;
      end
   end

   for (genvar i = 0; i < CLASSES; i++) begin : g_lane
      logic signed [23:0] acc_q, acc_d, sum, shifted;
      logic signed [16:0] px_s, w_s, prod;
      logic [7:0]         res_q, res_d, clamped;

      always_comb begin
         px_s    = 17'($signed({1'b0, bus.in_pixel}));
         w_s     = 17'($signed(bus.in_weights[i]));
         prod    = px_s * w_s;
         sum     = acc_q + 24'(prod);
         shifted = sum >>> SHIFT;
         if (shifted[23])                clamped = 8'd0;
         else if (shifted > 24'sd255)    clamped = 8'hFF;
         else                            clamped = shifted[7:0];

         acc_d = acc_q;
         res_d = res_q;
         if (release_out) begin
            acc_d = '0;
         end else if (accept) begin
            acc_d = sum;
            // The final beat's product goes straight into the result.
            if (last_beat) res_d = clamped;
         end
      end

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            acc_q <= '0;
            res_q <= '0;
         end else begin
            acc_q <= acc_d;
            res_q <= res_d;
         end
      end

      assign bus.result[i] = res_q;
   end
endmodule
